// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding
// to instruction memory, and registers instr/pc/nextPC for the next stage.
// A taken control transfer from execute outranks a hazard stall. A fetched
// hlt instruction freezes fetch until the next redirect or reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HLT_INSTR = 32'h0000_0073,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_nextPC,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ,   // presenting a request at pc
    S_WAIT,  // request accepted, waiting for its response
    S_HOLD,  // response buffered while the pipeline is stalled
    S_HALT   // hlt delivered, fetch frozen
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        kill, kill_next;       // the outstanding response is stale
  logic [31:0] hold_instr, hold_next; // response captured during a stall
  logic        deliver;               // an instruction reaches out_* this cycle
  logic [31:0] deliver_instr;

  // Requests and status come straight from registers, so there is no
  // combinational path from any memory input to imem_req/imem_addr.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  // Next-state, PC, kill flag and hold buffer; redirect is checked first.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_next    = state;
    pc_next       = pc;
    kill_next     = kill;
    hold_next     = hold_instr;
    deliver       = 1'b0;
    deliver_instr = hold_instr;

    if (redirect_valid) begin
      pc_next = redirect_target;
      if (state == S_WAIT && imem_rvalid) begin
        // The response lands together with the redirect: drop it here and
        // there is nothing left in flight to kill.
        state_next = S_REQ;
        kill_next  = 1'b0;
      end else if (state == S_WAIT || (state == S_REQ && imem_ready)) begin
        // A request to the old path is (or is about to be) in flight.
        state_next = S_WAIT;
        kill_next  = 1'b1;
      end else begin
        state_next = S_REQ;
        kill_next  = 1'b0;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_ready) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_next  = 1'b0;
              state_next = S_REQ;
            end else if (stall) begin
              hold_next  = imem_rdata;
              state_next = S_HOLD;
            end else begin
              deliver       = 1'b1;
              deliver_instr = imem_rdata;
            end
          end
        end
        S_HOLD: begin
          if (!stall) deliver = 1'b1;
        end
        S_HALT: begin
          state_next = S_HALT;
        end
        default: state_next = S_REQ;
      endcase

      if (deliver) begin
        pc_next    = pc + 32'd4;
        state_next = (deliver_instr == HLT_INSTR) ? S_HALT : S_REQ;
      end
    end
  end

  // FSM state, PC, kill flag and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      // NOTE: the hold buffer is a single register, not a memory array, so it
      // is reset too; only its use in S_HOLD matters, but the value stays known.
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      kill       <= kill_next;
      hold_instr <= hold_next;
    end
  end

  // Pipeline output register: redirect flushes, delivery loads, stall holds,
  // otherwise a bubble is presented while out_pc/out_nextPC keep their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_instr  <= NOP_INSTR;
      out_pc     <= 32'd0;
      out_nextPC <= 32'd0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end else if (deliver) begin
      out_valid  <= 1'b1;
      out_instr  <= deliver_instr;
      out_pc     <= pc;
      out_nextPC <= pc + 32'd4;
    end else if (!stall) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory answers each
// accepted request after a programmable number of extra cycles.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] HLT = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_nextPC;
  logic        halted;

  int vectors     = 0;
  int miscompares = 0;
  int mem_lat     = 0;

  logic        mem_pend;
  logic [31:0] mem_paddr;
  int          mem_cnt;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_nextPC     (out_nextPC),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Memory contents: NOPs below 0x10, two special words, otherwise a word
  // that encodes its own address so stale responses are recognisable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10)  return NOP;
    if (a == 32'h10) return 32'h00A0_0093;
    if (a == 32'h40) return HLT;
    return {a[19:0], 12'h013};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until out_valid is seen at a negedge, bounded.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc,
                           input logic [31:0] npc, input logic [31:0] instr);
    check({tag, " pc"},    out_pc,     pc);
    check({tag, " next"},  out_nextPC, npc);
    check({tag, " instr"}, out_instr,  instr);
  endtask

  // Memory model: handshake seen at posedge, response driven at a later negedge.
  initial begin
    mem_pend    = 1'b0;
    mem_paddr   = 32'd0;
    mem_cnt     = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst && imem_req && imem_ready) begin
        mem_pend  = 1'b1;
        mem_paddr = imem_addr;
        mem_cnt   = mem_lat;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_paddr);
          mem_pend    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int req_seen, valid_seen, unhalt_seen;
    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    imem_ready      = 1'b1;
    step(2);

    // Reset state
    check("rst valid",  32'(out_valid), 32'd0);
    check("rst instr",  out_instr,      NOP);
    check("rst pc",     out_pc,         32'd0);
    check("rst next",   out_nextPC,     32'd0);
    check("rst halted", 32'(halted),    32'd0);
    check("rst req",    32'(imem_req),  32'd1);
    check("rst addr",   imem_addr,      32'd0);
    rst = 1'b0;

    // Sequential fetch from 0
    wait_valid("seq0");
    check_out("seq0", 32'h0, 32'h4, NOP);
    check("seq0 addr", imem_addr, 32'h4);
    step(1);
    check("bubble valid", 32'(out_valid), 32'd0);
    check("bubble instr", out_instr,      NOP);
    check("bubble pc",    out_pc,         32'h0);
    wait_valid("seq4");
    check_out("seq4", 32'h4, 32'h8, NOP);
    wait_valid("seq8");
    check_out("seq8", 32'h8, 32'hC, NOP);
    wait_valid("seqC");
    check_out("seqC", 32'hC, 32'h10, NOP);

    // Stall for 3 cycles while the 0x10 response arrives
    step(1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall valid", 32'(out_valid), 32'd0);
      check("stall pc",    out_pc,         32'hC);
      check("stall req",   32'(imem_req),  32'd0);
    end
    stall = 1'b0;
    step(1);
    check("unstall valid", 32'(out_valid), 32'd1);
    check_out("unstall", 32'h10, 32'h14, 32'h00A0_0093);
    wait_valid("seq14");
    check_out("seq14", 32'h14, 32'h18, 32'h0001_4013);

    // Stall while a valid instruction sits in the output register
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("hold valid", 32'(out_valid), 32'd1);
      check("hold pc",    out_pc,         32'h14);
    end
    stall = 1'b0;
    wait_valid("seq18");
    check_out("seq18", 32'h18, 32'h1C, 32'h0001_8013);
    wait_valid("seq1C");
    check_out("seq1C", 32'h1C, 32'h20, 32'h0001_C013);

    // Redirect while waiting on a slow response for 0x20
    mem_lat = 2;
    step(1);
    check("wait20 addr", imem_addr,     32'h20);
    check("wait20 req",  32'(imem_req), 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    mem_lat        = 0;
    check("redir valid", 32'(out_valid), 32'd0);
    check("redir req",   32'(imem_req),  32'd0);
    check("redir addr",  imem_addr,      32'h200);
    wait_valid("tgt200");
    check_out("tgt200", 32'h200, 32'h204, 32'h0020_0013);

    // Redirect and stall together while out_valid is high
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    step(1);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    check("rs valid", 32'(out_valid), 32'd0);
    check("rs instr", out_instr,      NOP);
    check("rs pc",    out_pc,         32'h200);
    check("rs req",   32'(imem_req),  32'd0);
    check("rs addr",  imem_addr,      32'h300);
    wait_valid("tgt300");
    check_out("tgt300", 32'h300, 32'h304, 32'h0030_0013);

    // hlt at 0x40 freezes fetch
    redirect_valid  = 1'b1;
    redirect_target = 32'h3C;
    step(1);
    redirect_valid = 1'b0;
    wait_valid("tgt3C");
    check_out("tgt3C", 32'h3C, 32'h40, 32'h0003_C013);
    wait_valid("hlt");
    check_out("hlt", 32'h40, 32'h44, HLT);
    check("hlt halted", 32'(halted),   32'd1);
    check("hlt req",    32'(imem_req), 32'd0);
    req_seen    = 0;
    valid_seen  = 0;
    unhalt_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (imem_req)  req_seen++;
      if (out_valid) valid_seen++;
      if (!halted)   unhalt_seen++;
    end
    check("halt req cycles",    32'(req_seen),    32'd0);
    check("halt valid cycles",  32'(valid_seen),  32'd0);
    check("halt dropped",       32'(unhalt_seen), 32'd0);
    check("halt addr",          imem_addr,        32'h44);
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    check("unhalt halted", 32'(halted),   32'd0);
    check("unhalt req",    32'(imem_req), 32'd1);
    check("unhalt addr",   imem_addr,     32'h80);
    wait_valid("tgt80");
    check_out("tgt80", 32'h80, 32'h84, 32'h0008_0013);

    // Asynchronous reset in the middle of a wait; the late response is ignored
    mem_lat = 3;
    step(1);
    check("prerst req", 32'(imem_req), 32'd0);
    #2;
    rst        = 1'b1;
    imem_ready = 1'b0;
    #1;
    check("arst valid", 32'(out_valid), 32'd0);
    check("arst instr", out_instr,      NOP);
    check("arst pc",    out_pc,         32'd0);
    check("arst next",  out_nextPC,     32'd0);
    check("arst req",   32'(imem_req),  32'd1);
    check("arst addr",  imem_addr,      32'd0);
    step(1);
    rst        = 1'b0;
    valid_seen = 0;
    req_seen   = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (out_valid) valid_seen++;
      if (imem_req)  req_seen++;
    end
    check("late rvalid ignored", 32'(valid_seen), 32'd0);
    check("late req held",       32'(req_seen),   32'd6);
    check("late addr",           imem_addr,       32'd0);
    mem_lat    = 0;
    imem_ready = 1'b1;
    wait_valid("restart");
    check_out("restart", 32'h0, 32'h4, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 5-stage pipeline: owns the PC, issues single-outstanding requests to instruction memory, and delivers instr/pc/nextPC to the fetch/execute pipeline register.
- Handles stall from hazard detection, redirect (taken branch/jal/jalr) from execute, and freezes the processor on the hlt instruction.
- Bubbles are delivered as out_valid=0 with a canonical NOP.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- HLT_INSTR, 32'h0000_0073, encoding that freezes fetch
- NOP_INSTR, 32'h0000_0013, instruction presented on bubbles/flush (addi x0,x0,0)

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard unit: hold all out_* registers this cycle
- redirect_valid  input  1  execute resolved a taken control transfer
- redirect_target  input  32  new PC when redirect_valid
- imem_req  output  1  request valid to instruction memory
- imem_addr  output  32  request address (current PC)
- imem_ready  input  1  memory accepts request this cycle (req&&ready = handshake)
- imem_rvalid  input  1  response valid (exactly one per accepted request, ≥1 cycle later)
- imem_rdata  input  32  response instruction word
- out_valid  output  1  out_instr is a real instruction
- out_instr  output  32  fetched instruction
- out_pc  output  32  address of out_instr
- out_nextPC  output  32  out_pc + 4
- halted  output  1  fetch frozen on hlt

Behaviour:
- Reset (async, any time, including mid-request): pc=RESET_PC, state=REQ, kill=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_nextPC=0, halted=0. An in-flight memory response after reset is ignored only if it arrives while in REQ (rvalid is ignored outside WAIT).
- imem_req = (state==REQ); imem_addr = pc. Both are combinational from registers.
- States:
  - REQ: on imem_ready → WAIT.
  - WAIT: on imem_rvalid:
    - if kill: discard response, kill<=0, → REQ.
    - else if stall: latch rdata/pc into hold buffer, → HOLD.
    - else deliver: out_valid<=1, out_instr<=rdata, out_pc<=pc, out_nextPC<=pc+4, pc<=pc+4. If rdata==HLT_INSTR → HALT, else → REQ.
  - HOLD: when !stall, deliver the buffered instruction exactly as above (including the HLT check) → REQ/HALT.
  - HALT: halted=1, imem_req=0, pc frozen; exits only via redirect or reset.
- Output register rule: when stall=1 and no redirect, every out_* holds its value. When stall=0 and nothing is delivered this cycle, out_valid<=0 and out_instr<=NOP_INSTR; out_pc and out_nextPC hold.
- Redirect has highest priority and overrides stall:
  - pc<=redirect_target; out_valid<=0; out_instr<=NOP_INSTR; hold buffer is dropped.
  - From WAIT, or from REQ with imem_ready the same cycle: kill<=1, → WAIT. The stale response is discarded and the next request uses the target.
  - From REQ without ready, HOLD, or HALT: → REQ; halted<=0.
  - Redirect in the same cycle as a WAIT response: the response is discarded, kill is not set, → REQ.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. No alignment checks are performed.
- Latency: the earliest delivery is 2 cycles after the request cycle with 1-cycle memory (REQ, WAIT+rvalid, output registered). Throughput is at most one instruction per 2 cycles.
- HLT_INSTR is delivered downstream once with out_valid=1; out_valid=0 thereafter.

Test Plan:
- Reset, memory always ready, rvalid 1 cycle after request, rdata=NOP for PCs 0,4,8 → out_valid pulses with out_pc 0,4,8 and out_nextPC 4,8,12; imem_addr steps 0,4,8.
- stall=1 for 3 cycles while a response for pc=0x10 (rdata=0x00A00093) arrives → outputs frozen; on stall release, out_instr=0x00A00093 with out_pc=0x10; no fetch lost or duplicated.
- redirect_valid with target 0x200 while in WAIT for pc=0x20 → stale response discarded; the next imem_addr=0x200 and the next out_pc=0x200; out_valid=0 the cycle after redirect.
- redirect and stall asserted together → redirect wins: out_valid=0, next request to the target.
- rdata=0x00000073 at pc=0x40 → delivered once with out_pc=0x40; halted=1; imem_req stays 0 for 20 cycles; a redirect to 0x80 clears halted and fetches 0x80.
- rst asserted mid-WAIT for 1 cycle → all outputs return to reset values asynchronously; fetch restarts at RESET_PC; a late rvalid is ignored.
